// File: rtl/acc_param_if.sv
// Operation/result bundle for the parametrised accumulator.
// The master side issues operations (en/op/B); the slave side is the
// accumulator, which returns the running value, overflow flag and dump result.
interface acc_param_if #(
   parameter int W  = 8,
   parameter int BW = 3
);
   logic          en;
   logic [1:0]    op;
   logic [BW-1:0] B;
   logic [W-1:0]  Y;
   logic          ovf;
   logic [W-1:0]  R;
   logic          done;

   modport master (output en, op, B, input Y, ovf, R, done);
   modport slave  (input en, op, B, output Y, ovf, R, done);
endinterface

// File: rtl/acc_param.sv
// Parametrised accumulator: add/subtract/load/clear with saturating or
// wrapping overflow, a sticky overflow flag and an optional
// integrate-and-dump window of LEN counted operations.
module acc_param #(
   parameter int W   = 8,
   parameter int BW  = 3,
   parameter int SAT = 1,
   parameter int LEN = 0
) (
   input logic         clk,
   input logic         r,
   acc_param_if.slave  bus
);

   typedef enum logic [1:0] {
      OP_ADD   = 2'b00,
      OP_SUB   = 2'b01,
      OP_LOAD  = 2'b10,
      OP_CLEAR = 2'b11
   } op_t;

   // A window count of 0..LEN needs ceil(log2(LEN+1)) bits; keep one bit when
   // dumping is disabled so the register stays legal.
   localparam int            CW   = (LEN > 0) ? $clog2(LEN + 1) : 1;
   localparam bit            WIN  = (LEN > 0);
   localparam logic [CW-1:0] LAST = CW'((LEN > 0) ? LEN - 1 : 0);

   logic [W-1:0]  y_q;
   logic [W-1:0]  r_q;
   logic          ovf_q;
   logic          done_q;
   logic [CW-1:0] cnt_q;

   logic [W:0]    b_ext;
   logic [W:0]    sum;
   logic [W:0]    diff;
   logic [W-1:0]  result;
   logic          flow;
   logic          counted;
   logic          is_last;

   // Compute the candidate result of the presented operation one bit wider
   // than the accumulator, so the top bit flags overflow (add) or borrow (sub).
   always_comb begin
      b_ext   = {{(W + 1 - BW){1'b0}}, bus.B};
      sum     = {1'b0, y_q} + b_ext;
      diff    = {1'b0, y_q} - b_ext;
      result  = y_q;
      flow    = 1'b0;
      counted = 1'b0;
      case (op_t'(bus.op))
         OP_ADD: begin
            counted = 1'b1;
            flow    = sum[W];
            result  = (flow && (SAT != 0)) ? {W{1'b1}} : sum[W-1:0];
         end
         OP_SUB: begin
            counted = 1'b1;
            flow    = diff[W];
            result  = (flow && (SAT != 0)) ? {W{1'b0}} : diff[W-1:0];
         end
         OP_LOAD: begin
            counted = 1'b1;
            result  = b_ext[W-1:0];
         end
         default: begin
            result  = {W{1'b0}};
         end
      endcase
      is_last = WIN && (cnt_q == LAST);
   end

   // Register the accumulator, flag, window count and dump result; the last
   // counted operation of a window goes to R and the window restarts empty.
   always_ff @(posedge clk) begin
      if (r) begin
         y_q    <= '0;
         r_q    <= '0;
         ovf_q  <= 1'b0;
         done_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         done_q <= 1'b0;
         if (bus.en) begin
            if (!counted) begin
               y_q   <= '0;
               ovf_q <= 1'b0;
               cnt_q <= '0;
            end else begin
               if (flow) begin
                  ovf_q <= 1'b1;
               end
               if (is_last) begin
                  r_q    <= result;
                  done_q <= 1'b1;
                  y_q    <= '0;
                  cnt_q  <= '0;
               end else begin
                  y_q <= result;
                  if (WIN) begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
            end
         end
      end
   end

   assign bus.Y    = y_q;
   assign bus.R    = r_q;
   assign bus.ovf  = ovf_q;
   assign bus.done = done_q;

endmodule
